// File: rtl/life_pattern_loader.sv
// ============================================================================
// Module      : life_pattern_loader
// Description : Writer-side front end for the life cell array. Unpacks a
//               valid/ready byte stream into a ROWS*COLS shadow frame, commits
//               it to every cell in one cycle (load_write/load_val) and holds
//               the generation enable low while a load is in progress.
//               Optional checksum build: define LIFE_LOADER_CHECKSUM_EN to
//               require a trailing XOR byte before the frame is committed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module life_pattern_loader #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 run,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ROWS*COLS-1:0] load_val,
  output logic                 load_write,
  output logic                 run_enb,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int N      = ROWS * COLS;
  localparam int NBYTES = (N + 7) / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(NBYTES - 1);

`ifdef LIFE_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECV   = 2'd1,
    S_COMMIT = 2'd2,
    S_CHECK  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECV   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [N-1:0]    shadow_q, shadow_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;

`ifdef LIFE_LOADER_CHECKSUM_EN
  logic [7:0]      acc_q, acc_d;
  logic            err_q, err_d;
`endif

  // Per-cell write enable for the byte currently being received, and the
  // incoming byte replicated so cell k sees bit k%8. Cells past N simply do
  // not exist, which is how the unused bits of the last byte are dropped.
  logic [N-1:0]    w_bit_we;
  logic [N-1:0]    w_bit_data;

  generate
    for (genvar k = 0; k < N; k++) begin : g_bit
      assign w_bit_we[k]   = (cnt_q == CW'(k / 8));
      assign w_bit_data[k] = in_data[k % 8];
    end
  endgenerate

  // Next-state, datapath update and handshake/strobe outputs.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    in_ready   = 1'b0;
    load_write = 1'b0;
    run_enb    = 1'b0;
`ifdef LIFE_LOADER_CHECKSUM_EN
    acc_d      = acc_q;
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        run_enb = run;
        if (start) begin
          state_d  = S_RECV;
          shadow_d = '0;
          cnt_d    = '0;
`ifdef LIFE_LOADER_CHECKSUM_EN
          acc_d    = 8'h00;
          err_d    = 1'b0;
`endif
        end
      end
      S_RECV: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shadow_d = (shadow_q & ~w_bit_we) | (w_bit_data & w_bit_we);
          cnt_d    = cnt_q + CW'(1);
`ifdef LIFE_LOADER_CHECKSUM_EN
          acc_d    = acc_q ^ in_data;
          if (cnt_q == C_LAST) begin
            state_d = S_CHECK;
          end
`else
          if (cnt_q == C_LAST) begin
            state_d = S_COMMIT;
          end
`endif
        end
      end
`ifdef LIFE_LOADER_CHECKSUM_EN
      S_CHECK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_data == acc_q) begin
            state_d = S_COMMIT;
          end else begin
            // Keep the shadow for inspection but never commit it.
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      S_COMMIT: begin
        load_write = 1'b1;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
`ifdef LIFE_LOADER_CHECKSUM_EN
      acc_q    <= 8'h00;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
`ifdef LIFE_LOADER_CHECKSUM_EN
      acc_q    <= acc_d;
      err_q    <= err_d;
`endif
    end
  end

  assign load_val = shadow_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
`ifdef LIFE_LOADER_CHECKSUM_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_life_pattern_loader.sv
// ============================================================================
// Module      : tb_life_pattern_loader
// Description : Scoreboard bench for life_pattern_loader. Two instances
//               (4x4 and 3x3, both two bytes per frame) share one stimulus
//               stream; committed frames are queued at issue time and popped
//               by a monitor whenever load_write is seen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_life_pattern_loader;

  logic        clk = 1'b0;
  logic        reset, start, run, in_valid;
  logic [7:0]  in_data;

  logic        rdy16, lw16, enb16, busy16, done16, err16;
  logic [15:0] val16;
  logic        rdy9, lw9, enb9, busy9, done9, err9;
  logic [8:0]  val9;

  always #5 clk = ~clk;

  life_pattern_loader #(.ROWS(4), .COLS(4)) u_dut16 (
    .clk(clk), .reset(reset), .start(start), .run(run),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy16),
    .load_val(val16), .load_write(lw16), .run_enb(enb16),
    .busy(busy16), .done(done16), .err(err16)
  );

  life_pattern_loader #(.ROWS(3), .COLS(3)) u_dut9 (
    .clk(clk), .reset(reset), .start(start), .run(run),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy9),
    .load_val(val9), .load_write(lw9), .run_enb(enb9),
    .busy(busy9), .done(done9), .err(err9)
  );

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t        q16[$];
  exp_t        q9[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          writes_exp = 0;
  int          writes16 = 0;
  int          writes9 = 0;
  bit          chk_en = 1'b0;
  logic        exp_ready, exp_busy, exp_write, exp_done, exp_err, hold_valid;
  logic [31:0] hold16, hold9;
`ifdef LIFE_LOADER_CHECKSUM_EN
  bit          bad_next = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    run = 1'($urandom_range(0, 1));
  endtask

  // Monitor: per-cycle control expectations plus scoreboard pop on commit.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      check("in_ready16", 32'(rdy16), 32'(exp_ready));
      check("in_ready9", 32'(rdy9), 32'(exp_ready));
      check("busy16", 32'(busy16), 32'(exp_busy));
      check("busy9", 32'(busy9), 32'(exp_busy));
      check("load_write16", 32'(lw16), 32'(exp_write));
      check("load_write9", 32'(lw9), 32'(exp_write));
      check("done16", 32'(done16), 32'(exp_done));
      check("done9", 32'(done9), 32'(exp_done));
      check("err16", 32'(err16), 32'(exp_err));
      check("run_enb16", 32'(enb16), 32'(run & ~exp_busy));
      check("run_enb9", 32'(enb9), 32'(run & ~exp_busy));
      if (hold_valid) begin
        check("load_val16_hold", 32'(val16), hold16);
        check("load_val9_hold", 32'(val9), hold9);
      end
      if (lw16 === 1'b1) begin
        writes16++;
        check("write16_expected", 32'(q16.size() > 0), 32'd1);
        if (q16.size() > 0) begin
          e = q16.pop_front();
          check("load_val16", 32'(val16), e.val);
          check("commit_cycle16", 32'(cyc), 32'(e.cyc));
        end
      end
      if (lw9 === 1'b1) begin
        writes9++;
        check("write9_expected", 32'(q9.size() > 0), 32'd1);
        if (q9.size() > 0) begin
          e = q9.pop_front();
          check("load_val9", 32'(val9), e.val);
          check("commit_cycle9", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      start    = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      tick();
    end
  endtask

  // One frame transaction: start, byte 0, optional stall, byte 1, commit.
  task automatic do_load(input logic [7:0] b0, input logic [7:0] b1,
                         input int gap, input bit abort);
    logic [31:0] f16, f9;
`ifdef LIFE_LOADER_CHECKSUM_EN
    logic [7:0]  cks;
`endif
    f16 = {16'h0000, b1, b0};
    f9  = {23'h0, b1[0], b0};

    // Start cycle: still idle, so a valid byte here must be ignored.
    start     = 1'b1;
    in_valid  = 1'($urandom_range(0, 1));
    in_data   = 8'($urandom);
    exp_busy  = 1'b0;
    exp_ready = 1'b0;
    exp_write = 1'b0;
    exp_done  = 1'b0;
    tick();

    start      = 1'b0;
    exp_busy   = 1'b1;
    exp_ready  = 1'b1;
    exp_err    = 1'b0;
    hold_valid = 1'b0;
    in_valid   = 1'b1;
    in_data    = b0;
    tick();

    // Stall with in_valid low; stray start pulses must not matter.
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      start    = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;

    if (abort) begin
      in_valid = 1'b0;
      reset    = 1'b1;
      tick();
      reset      = 1'b0;
      exp_busy   = 1'b0;
      exp_ready  = 1'b0;
      hold16     = 32'h0;
      hold9      = 32'h0;
      hold_valid = 1'b1;
      return;
    end

    in_valid = 1'b1;
    in_data  = b1;
`ifdef LIFE_LOADER_CHECKSUM_EN
    tick();
    cks      = b0 ^ b1 ^ {7'h00, bad_next};
    in_data  = cks;
    if (bad_next) begin
      tick();
      in_valid   = 1'b0;
      exp_busy   = 1'b0;
      exp_ready  = 1'b0;
      exp_err    = 1'b1;
      hold16     = f16;
      hold9      = f9;
      hold_valid = 1'b1;
      return;
    end
`endif
    q16.push_back('{val: f16, cyc: cyc + 1});
    q9.push_back('{val: f9, cyc: cyc + 1});
    writes_exp++;
    tick();

    // Commit cycle: in_ready is low, so this byte must be ignored too.
    in_valid  = 1'b1;
    in_data   = 8'($urandom);
    exp_ready = 1'b0;
    exp_write = 1'b1;
    tick();

    in_valid   = 1'b0;
    exp_write  = 1'b0;
    exp_busy   = 1'b0;
    exp_done   = 1'b1;
    hold16     = f16;
    hold9      = f9;
    hold_valid = 1'b1;
    tick();
    exp_done = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    run        = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    exp_ready  = 1'b0;
    exp_busy   = 1'b0;
    exp_write  = 1'b0;
    exp_done   = 1'b0;
    exp_err    = 1'b0;
    hold16     = 32'h0;
    hold9      = 32'h0;
    hold_valid = 1'b1;

    @(posedge clk);
    #1;
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    idle(3);

    do_load(8'hA5, 8'h3C, 0, 1'b0);
    idle(2);
    do_load(8'h01, 8'h80, 5, 1'b0);
    idle(1);
    do_load(8'hFF, 8'hFF, 0, 1'b0);
    idle(1);
    do_load(8'h55, 8'h00, 2, 1'b1);
    idle(2);
    do_load(8'h0F, 8'hF0, 0, 1'b0);
    idle(1);

`ifdef LIFE_LOADER_CHECKSUM_EN
    bad_next = 1'b0;
    do_load(8'h12, 8'h34, 0, 1'b0);
    idle(1);
    bad_next = 1'b1;
    do_load(8'h12, 8'h34, 0, 1'b0);
    idle(3);
    bad_next = 1'b0;
    do_load(8'h12, 8'h34, 1, 1'b0);
    idle(1);
`endif

    for (int n = 0; n < 30; n++) begin
`ifdef LIFE_LOADER_CHECKSUM_EN
      bad_next = ($urandom_range(0, 3) == 0);
`endif
      do_load(8'($urandom), 8'($urandom), $urandom_range(0, 4),
              ($urandom_range(0, 7) == 0));
      idle($urandom_range(0, 3));
    end
    idle(3);

    check("write_count16", 32'(writes16), 32'(writes_exp));
    check("write_count9", 32'(writes9), 32'(writes_exp));
    check("queue16_drained", 32'(q16.size()), 32'd0);
    check("queue9_drained", 32'(q9.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
